// File: rtl/bram_responder_if.sv
// Load/store memory interface between a controller (master) and a memory responder (slave).
// Carries the request strobe, write data, read response and the responder's status counters.
interface bram_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  rd_err;
  logic                  wr_ack;
  logic                  wr_err;
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;
  logic [15:0]           err_count;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid, rd_err, wr_ack, wr_err,
    input  rd_count, wr_count, err_count
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid, rd_err, wr_ack, wr_err,
    output rd_count, wr_count, err_count
  );
endinterface

// File: rtl/bram_responder.sv
// BRAM endpoint for the load/store memory interface: fixed-latency pipelined reads,
// immediate write commit, address fault reporting and saturating access counters.
module bram_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  bram_responder_if.slave bus
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IDX = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  logic                  misaligned;
  logic                  out_of_range;
  logic                  fault;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [IDX-1:0]        word_idx;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [READ_LATENCY-1:0] pipe_err_reg;
  logic [DATA_WIDTH-1:0]   pipe_data_reg [READ_LATENCY];

  logic                  wr_ack_reg;
  logic                  wr_err_reg;

  logic [1:0]            cnt_inc   [3];
  logic [15:0]           cnt_value [3];

  // Mask test rather than a slice so byte-wide words (no offset bits) still elaborate.
  assign misaligned   = (bus.mem_addr & OFF_MASK) != '0;
  assign out_of_range = (bus.mem_addr >> (OFF + IDX)) != '0;
  assign fault        = misaligned | out_of_range;
  assign word_idx     = bus.mem_addr[OFF+IDX-1:OFF];
  assign rd_fire      = bus.mem_en & ~bus.mem_wr;
  assign wr_fire      = bus.mem_en & bus.mem_wr;

  always_ff @(posedge clk) begin
    if (wr_fire && !fault) begin
      mem_array[word_idx] <= bus.mem_wdata;
    end
  end

  // Stage 0 captures the array word; later stages only move data when a response is
  // travelling, so the last stage (mem_rdata) holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= '0;
      pipe_err_reg   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data_reg[i] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= rd_fire;
      pipe_err_reg[0]   <= rd_fire & fault;
      if (rd_fire) begin
        pipe_data_reg[0] <= fault ? '0 : mem_array[word_idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_err_reg[i]   <= pipe_err_reg[i-1];
        if (pipe_valid_reg[i-1]) begin
          pipe_data_reg[i] <= pipe_data_reg[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_reg <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      wr_ack_reg <= wr_fire;
      wr_err_reg <= wr_fire & fault;
    end
  end

  assign bus.mem_rdata  = pipe_data_reg[READ_LATENCY-1];
  assign bus.mem_rvalid = pipe_valid_reg[READ_LATENCY-1];
  assign bus.rd_err     = pipe_err_reg[READ_LATENCY-1];
  assign bus.wr_ack     = wr_ack_reg;
  assign bus.wr_err     = wr_err_reg;

  // Counter 0: reads, 1: writes, 2: faults (a read and a write fault together add 2).
  assign cnt_inc[0] = {1'b0, pipe_valid_reg[READ_LATENCY-1]};
  assign cnt_inc[1] = {1'b0, wr_ack_reg};
  assign cnt_inc[2] = {1'b0, pipe_err_reg[READ_LATENCY-1]} + {1'b0, wr_err_reg};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    logic [16:0] sum_next;

    assign sum_next = {1'b0, cnt_reg} + {15'd0, cnt_inc[gi]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= sum_next[16] ? 16'hFFFF : sum_next[15:0];
      end
    end

    assign cnt_value[gi] = cnt_reg;
  end

  assign bus.rd_count  = cnt_value[0];
  assign bus.wr_count  = cnt_value[1];
  assign bus.err_count = cnt_value[2];
endmodule

// File: tb/tb_bram_responder.sv
// Self-checking bench for bram_responder: directed scenarios plus a randomized run
// scored against a word-array reference model with per-cycle response expectations.
module tb_bram_responder;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int RL    = 3;
  localparam int BYTES = DW / 8;
  localparam int OFFB  = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  typedef struct { int due; logic [DW-1:0] data; bit err; bit known; } rd_exp_t;
  typedef struct { int due; bit err; } wr_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  int exp_rd  = 0;
  int exp_wr  = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  bram_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic bit is_fault(logic [AW-1:0] a);
    return (a % BYTES != 0) || (a >= AW'(DEPTH * BYTES));
  endfunction

  function automatic logic [IW-1:0] widx(logic [AW-1:0] a);
    return IW'(a / BYTES);
  endfunction

  function automatic logic [15:0] sat(int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // One request cycle; the model commits at the sampling edge, outputs are sampled 1 unit later.
  task automatic drive(bit en, bit wr, logic [AW-1:0] addr, logic [DW-1:0] wdata);
    @(negedge clk);
    bus.mem_en    = en;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    @(posedge clk);
    if (en) begin
      if (wr) exp_wr++;
      else    exp_rd++;
      if (is_fault(addr)) exp_err++;
      else if (wr) begin
        ref_mem[widx(addr)]   = wdata;
        ref_known[widx(addr)] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic test_reset();
    logic [DW-1:0] got [8];
    string names [8];
    names = '{"rdata", "rvalid", "rd_err", "wr_ack", "wr_err", "rd_count", "wr_count", "err_count"};
    bus.mem_en = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got[0] = bus.mem_rdata;
    got[1] = DW'(bus.mem_rvalid);
    got[2] = DW'(bus.rd_err);
    got[3] = DW'(bus.wr_ack);
    got[4] = DW'(bus.wr_err);
    got[5] = DW'(bus.rd_count);
    got[6] = DW'(bus.wr_count);
    got[7] = DW'(bus.err_count);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== '0) begin
        bad++;
        $display("FAIL reset_%s got=%0h want=0", names[i], got[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    total++;
    if (bus.wr_ack !== 1'b1 || bus.wr_err !== 1'b0) begin
      bad++; $display("FAIL basic_wr_ack got=%b/%b want=1/0", bus.wr_ack, bus.wr_err);
    end
    drive(1'b0, 1'b0, 32'h10, $urandom);
    drive(1'b1, 1'b0, 32'h10, $urandom);
    total++;
    if (bus.wr_ack !== 1'b0) begin
      bad++; $display("FAIL basic_wr_ack_pulse got=%b want=0", bus.wr_ack);
    end
    for (int k = 0; k < RL; k++) begin
      if (k > 0) idle();
      total++;
      if (bus.mem_rvalid !== (k == RL - 1)) begin
        bad++; $display("FAIL basic_rvalid k=%0d got=%b want=%b", k, bus.mem_rvalid, k == RL - 1);
      end
    end
    total++;
    if (bus.mem_rdata !== 32'hDEADBEEF || bus.rd_err !== 1'b0) begin
      bad++; $display("FAIL basic_rdata got=%h err=%b want=deadbeef err=0", bus.mem_rdata, bus.rd_err);
    end
    repeat (2) idle();
    total++;
    if (bus.rd_count !== sat(exp_rd) || bus.wr_count !== sat(exp_wr)) begin
      bad++; $display("FAIL basic_counts got rd=%0d wr=%0d want rd=%0d wr=%0d",
                      bus.rd_count, bus.wr_count, sat(exp_rd), sat(exp_wr));
    end
  endtask

  task automatic test_pipelined();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, AW'(4 * i), DW'(32'hA0 + i));
    for (int j = 0; j < RL + 4; j++) begin
      if (j < 4) drive(1'b1, 1'b0, AW'(4 * j), $urandom);
      else idle();
      total++;
      if (bus.mem_rvalid !== (j >= RL - 1 && j < RL + 3)) begin
        bad++; $display("FAIL pipe_rvalid j=%0d got=%b", j, bus.mem_rvalid);
      end else if (bus.mem_rvalid && bus.mem_rdata !== DW'(32'hA0 + j - (RL - 1))) begin
        bad++; $display("FAIL pipe_rdata j=%0d got=%h want=%h", j, bus.mem_rdata, 32'hA0 + j - (RL - 1));
      end
    end
  endtask

  task automatic test_faults();
    logic [DW-1:0] word0;
    repeat (RL + 1) idle();
    drive(1'b1, 1'b1, 32'h400, 32'h55);
    total++;
    if (bus.wr_ack !== 1'b1 || bus.wr_err !== 1'b1) begin
      bad++; $display("FAIL fault_wr got ack=%b err=%b want 1/1", bus.wr_ack, bus.wr_err);
    end
    drive(1'b1, 1'b0, 32'h002, $urandom);
    repeat (RL - 1) idle();
    total++;
    if (bus.mem_rvalid !== 1'b1 || bus.rd_err !== 1'b1 || bus.mem_rdata !== '0) begin
      bad++; $display("FAIL fault_rd got v=%b err=%b data=%h want 1/1/0",
                      bus.mem_rvalid, bus.rd_err, bus.mem_rdata);
    end
    word0 = ref_mem[0];
    drive(1'b1, 1'b0, 32'h0, $urandom);
    repeat (RL - 1) idle();
    total++;
    if (bus.mem_rdata !== word0 || bus.rd_err !== 1'b0) begin
      bad++; $display("FAIL fault_word0 got=%h want=%h", bus.mem_rdata, word0);
    end
    idle();
    total++;
    if (bus.err_count !== sat(exp_err)) begin
      bad++; $display("FAIL fault_err_count got=%0d want=%0d", bus.err_count, sat(exp_err));
    end
  endtask

  task automatic test_concurrent();
    logic [AW-1:0] addr_r, addr_w;
    logic [DW-1:0] want;
    int base;
    for (int f = 0; f < 2; f++) begin
      addr_r = (f == 1) ? 32'h2   : 32'h10;
      addr_w = (f == 1) ? 32'h800 : 32'h20;
      want   = (f == 1) ? '0 : ref_mem[widx(addr_r)];
      repeat (RL + 1) idle();
      base = exp_err;
      for (int j = 0; j <= RL; j++) begin
        if (j == 0) drive(1'b1, 1'b0, addr_r, $urandom);
        else if (j == RL - 1) drive(1'b1, 1'b1, addr_w, $urandom);
        else idle();
        if (j == RL - 1) begin
          total++;
          if (bus.mem_rvalid !== 1'b1 || bus.wr_ack !== 1'b1 || bus.rd_err !== 1'(f) ||
              bus.wr_err !== 1'(f) || bus.mem_rdata !== want) begin
            bad++; $display("FAIL conc_both f=%0d got v=%b a=%b re=%b we=%b d=%h want 1/1/%0d/%0d/%h",
                            f, bus.mem_rvalid, bus.wr_ack, bus.rd_err, bus.wr_err, bus.mem_rdata, f, f, want);
          end
          total++;
          if (bus.err_count !== sat(base)) begin
            bad++; $display("FAIL conc_err_before f=%0d got=%0d want=%0d", f, bus.err_count, sat(base));
          end
        end
        if (j == RL) begin
          total++;
          if (bus.err_count !== sat(base + 2 * f)) begin
            bad++; $display("FAIL conc_err_step f=%0d got=%0d want=%0d", f, bus.err_count, sat(base + 2 * f));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    rd_exp_t rq[$];
    wr_exp_t wq[$];
    rd_exp_t e;
    wr_exp_t w;
    logic [AW-1:0] addr;
    logic [DW-1:0] last_data;
    bit en, wr, f, exp_v, exp_a, last_known;
    int r;
    last_known = 1'b0;
    last_data  = '0;
    repeat (RL + 1) idle();
    for (int n = 0; n < 400 + RL + 1; n++) begin
      en   = (n < 400) && ($urandom_range(0, 3) != 0);
      wr   = 1'($urandom);
      r    = $urandom_range(0, 7);
      addr = AW'($urandom_range(0, (r < 4) ? 15 : DEPTH - 1)) * AW'(BYTES);
      if (r == 0) addr = addr + AW'($urandom_range(1, BYTES - 1));
      else if (r == 1) addr = addr | (AW'(1) << $urandom_range(OFFB + IW, AW - 1));
      f = is_fault(addr);
      if (en && !wr) begin
        e.due   = n + RL - 1;
        e.err   = f;
        e.data  = f ? '0 : ref_mem[widx(addr)];
        e.known = f ? 1'b1 : ref_known[widx(addr)];
        rq.push_back(e);
      end
      if (en && wr) begin
        w.due = n;
        w.err = f;
        wq.push_back(w);
      end
      drive(en, wr, addr, $urandom);
      exp_v = (rq.size() > 0) && (rq[0].due == n);
      total++;
      if (bus.mem_rvalid !== exp_v) begin
        bad++; $display("FAIL rand_rvalid n=%0d got=%b want=%b", n, bus.mem_rvalid, exp_v);
      end
      if (exp_v) begin
        e = rq.pop_front();
        last_data  = e.data;
        last_known = e.known;
        total++;
        if (bus.rd_err !== e.err || (e.known && bus.mem_rdata !== e.data)) begin
          bad++; $display("FAIL rand_rdata n=%0d got err=%b data=%h want err=%b data=%h",
                          n, bus.rd_err, bus.mem_rdata, e.err, e.data);
        end
      end else if (last_known) begin
        total++;
        if (bus.mem_rdata !== last_data) begin
          bad++; $display("FAIL rand_hold n=%0d got=%h want=%h", n, bus.mem_rdata, last_data);
        end
      end
      exp_a = (wq.size() > 0) && (wq[0].due == n);
      total++;
      if (bus.wr_ack !== exp_a || (exp_a && bus.wr_err !== wq[0].err)) begin
        bad++; $display("FAIL rand_wr_ack n=%0d got ack=%b err=%b want ack=%b", n, bus.wr_ack, bus.wr_err, exp_a);
      end
      if (exp_a) w = wq.pop_front();
    end
    idle();
    total++;
    if (bus.rd_count !== sat(exp_rd) || bus.wr_count !== sat(exp_wr) || bus.err_count !== sat(exp_err)) begin
      bad++; $display("FAIL rand_counts got rd=%0d wr=%0d err=%0d want rd=%0d wr=%0d err=%0d",
                      bus.rd_count, bus.wr_count, bus.err_count, sat(exp_rd), sat(exp_wr), sat(exp_err));
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] want;
    int saw;
    want = ref_mem[widx(32'h10)];
    repeat (RL + 1) idle();
    drive(1'b1, 1'b0, 32'h10, $urandom);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (bus.mem_rvalid === 1'b1) saw++;
    end
    total++;
    if (saw != 0) begin
      bad++; $display("FAIL rstmid_rvalid got=%0d pulses want=0", saw);
    end
    total++;
    if (bus.rd_count !== 16'd0 || bus.wr_count !== 16'd0 || bus.err_count !== 16'd0) begin
      bad++; $display("FAIL rstmid_counts got rd=%0d wr=%0d err=%0d want 0",
                      bus.rd_count, bus.wr_count, bus.err_count);
    end
    drive(1'b1, 1'b0, 32'h10, $urandom);
    repeat (RL - 1) idle();
    total++;
    if (bus.mem_rvalid !== 1'b1 || bus.mem_rdata !== want) begin
      bad++; $display("FAIL rstmid_data got v=%b data=%h want 1/%h", bus.mem_rvalid, bus.mem_rdata, want);
    end
    idle();
    total++;
    if (bus.rd_count !== sat(exp_rd)) begin
      bad++; $display("FAIL rstmid_rd_count got=%0d want=%0d", bus.rd_count, sat(exp_rd));
    end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    repeat (RL + 1) idle();
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 1'b0, 32'h10, $urandom);
      if (bus.mem_rvalid === 1'b1) pulses++;
    end
    repeat (RL + 1) begin
      idle();
      if (bus.mem_rvalid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 65540) begin
      bad++; $display("FAIL sat_pulses got=%0d want=65540", pulses);
    end
    total++;
    if (bus.rd_count !== sat(exp_rd)) begin
      bad++; $display("FAIL sat_rd_count got=%h want=%h", bus.rd_count, sat(exp_rd));
    end
    total++;
    if (bus.wr_count !== sat(exp_wr)) begin
      bad++; $display("FAIL sat_wr_count got=%0d want=%0d", bus.wr_count, sat(exp_wr));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_pipelined();
    test_faults();
    test_concurrent();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_responder.md
# bram_responder

Memory-side responder for the load/store memory interface: accepts single-cycle `mem_en` requests from a load-store controller, commits writes to an internal word array, and returns read data with a fixed, parameterised latency. Reads are fully pipelined and may be issued every cycle. The block also reports address faults and keeps saturating access counters. It is the BRAM endpoint in the load-store subsystem and serves as the synthesizable memory model for controller testbenches.

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8 and a power of 2.
- `DEPTH`, 256: number of words; must be a power of 2 and at least 2.
- `READ_LATENCY`, 1: cycles from read acceptance to `mem_rvalid`; legal range 1..4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_en` in 1: request strobe; one request per cycle in which it is high.
- `mem_wr` in 1: 1 = write, 0 = read; sampled only when `mem_en` = 1.
- `mem_addr` in ADDR_WIDTH: byte address.
- `mem_wdata` in DATA_WIDTH: write data.
- `mem_rdata` out DATA_WIDTH: read data; holds its value between responses.
- `mem_rvalid` out 1: one-cycle pulse per read response.
- `rd_err` out 1: qualifies `mem_rvalid`; the read address was faulty.
- `wr_ack` out 1: one-cycle pulse per accepted write.
- `wr_err` out 1: qualifies `wr_ack`; the write was faulty and was dropped.
- `rd_count` out 16: completed reads, saturating at 0xFFFF.
- `wr_count` out 16: completed writes, saturating at 0xFFFF.
- `err_count` out 16: faulty accesses (read or write), saturating at 0xFFFF.

## Operation
- **Address decode.**
  - `OFF` = log2(DATA_WIDTH/8).
  - `IDX` = log2(DEPTH).
  - Word index = `mem_addr[OFF+IDX-1:OFF]`.
- **Faults.**
  - Misaligned: `mem_addr[OFF-1:0]` ≠ 0.
  - Out of range: `mem_addr[ADDR_WIDTH-1:OFF+IDX]` ≠ 0.
  - Either condition makes the access faulty.
- **Write** (`mem_en`=1, `mem_wr`=1).
  - Non-faulty: the array word is updated at the sampling edge.
  - Faulty: the array is unchanged.
  - Either way, `wr_ack` is high the next cycle, with `wr_err` = fault.
- **Read** (`mem_en`=1, `mem_wr`=0).
  - The array word, or 0 if faulty, enters a READ_LATENCY-stage pipeline together with valid and fault bits.
  - The last stage drives `mem_rdata`, `mem_rvalid` and `rd_err`.
  - `mem_rdata` updates only when a response emerges.
- **Ordering.** Responses return in issue order, one per read, and none are dropped.
- **No backpressure.** The block is always ready; there is no ready signal.
- **Counters.**
  - `rd_count` increments on `mem_rvalid`; `wr_count` increments on `wr_ack`. Faulty accesses are included in both.
  - `err_count` increments by 1 on `rd_err` or `wr_err`, and by 2 when both occur in the same cycle (still saturating).
- **Array state.** The array is not reset, and its contents survive `rst_n`. Reads of words never written return X in simulation, and the bench must not check them.

## Timing
- **Reset values** (asynchronous assert): `mem_rdata`=0, `mem_rvalid`=0, `rd_err`=0, `wr_ack`=0, `wr_err`=0, all counters 0, all pipeline valid bits 0.
- **Read latency.** A read sampled at edge E produces a response visible after edge E+READ_LATENCY-1.
  - With READ_LATENCY=1, a request in cycle 0 gives `mem_rvalid` in cycle 1.
- **Write latency.** A write sampled at edge E has `wr_ack` visible in the next cycle.
- **Back-to-back reads.** N consecutive read cycles give N consecutive `mem_rvalid` cycles.
- **Read-after-write.** Write at cycle k, read of the same address at cycle k+1: the read returns the new data. There is no bypass path because the write commits at the edge ending cycle k.
- **Simultaneous events.** With READ_LATENCY ≥ 2, `mem_rvalid` and `wr_ack` may be high in the same cycle. Both are reported independently.
- **Reset mid-operation.** In-flight reads are discarded. No `mem_rvalid` appears after `rst_n` deasserts until a new read is issued.
- **Ignored inputs.** `mem_wr`, `mem_addr` and `mem_wdata` are ignored when `mem_en`=0.

## Test plan
- **Basic write/read, READ_LATENCY=1.** Write 0xDEADBEEF to 0x10, then read 0x10 in the next cycle -> `wr_ack` in cycle 1, `mem_rvalid` in cycle 2 with `mem_rdata`=0xDEADBEEF, `rd_err`=0, `wr_count`=1, `rd_count`=1.
- **Pipelined reads, READ_LATENCY=3.** Preload words 0..3 with 0xA0..0xA3, then read 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four consecutive `mem_rvalid` pulses, starting 3 cycles after the first read, with data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- **Faults, DEPTH=256.**
  - Write 0x55 to 0x400 -> `wr_ack`=1 and `wr_err`=1; word 0 is unchanged.
  - Read 0x002 -> `rd_err`=1 and `mem_rdata`=0.
  - After both, `err_count`=2.
- **Concurrent events, READ_LATENCY=2.** Read at cycle 0, write at cycle 1 -> `mem_rvalid` and `wr_ack` both high in cycle 2. Repeat the read and the write faulty -> `err_count` steps from 0 to 2 in a single cycle.
- **Reset mid-operation.** With READ_LATENCY=4, issue a read, then pulse `rst_n` low 2 cycles later -> `mem_rvalid` never rises. A following read of a previously written address returns the pre-reset data, and all counters restart from 0.
- **Counter saturation.** Issue 65,540 reads -> `rd_count` holds at 0xFFFF and does not wrap.
